// File: rtl/jam_pkg.sv
// Shared definitions for the job-assignment cost server: widths, FSM states, table indexing.
package jam_pkg;
    localparam int JAM_N  = 8;
    localparam int COST_W = 7;
    localparam int SUM_W  = 10;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } jam_state_e;

    // Row-major table index: worker selects the row, job the column.
    function automatic logic [5:0] jam_idx(input logic [2:0] w, input logic [2:0] j);
        return {w, j};
    endfunction
endpackage

// File: rtl/jam_cost_table.sv
// Cost register file: one synchronous write port, one combinational read port, no reset.
module jam_cost_table #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 7,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/jam_cost_server.sv
// Cost table responder for the assignment engine: streamed load, same-cycle lookup, result capture.
// Optional JAM_QUERY_CNT_EN adds a saturating count of distinct lookups while serving.
module jam_cost_server #(
    parameter int N_WORKERS = 8,
    parameter int COST_W    = 7
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       load_valid,
    input  logic [COST_W-1:0]          load_data,
    output logic                       load_ready,
    input  logic [2:0]                 W,
    input  logic [2:0]                 J,
    output logic [COST_W-1:0]          Cost,
    input  logic                       Valid,
    input  logic [jam_pkg::SUM_W-1:0]  MinCost,
    input  logic [jam_pkg::CNT_W-1:0]  MatchCount,
    output logic                       table_full,
    output logic                       res_valid,
    output logic [jam_pkg::SUM_W-1:0]  res_min_cost,
    output logic [jam_pkg::CNT_W-1:0]  res_match_count,
    output logic                       err,
    input  logic                       restart,
    output logic [15:0]                query_cnt
);
    import jam_pkg::*;

    localparam int DEPTH = N_WORKERS * N_WORKERS;
    localparam int AW    = $clog2(DEPTH);

    jam_state_e        state_q, state_d;
    logic [AW-1:0]     idx_q;
    logic              we;
    logic [COST_W-1:0] rdata;

    always_ff @(posedge CLK) begin
        if (RST) state_q <= LOAD;
        else     state_q <= state_d;
    end

    // Valid and restart together in DONE: the restart arm is the only exit, so Valid is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (load_valid && idx_q == AW'(DEPTH - 1)) state_d = SERVE;
            SERVE:   if (Valid) state_d = DONE;
            DONE:    if (restart) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    assign we         = (state_q == LOAD) && load_valid;
    assign load_ready = (state_q == LOAD);
    assign table_full = (state_q != LOAD);
    assign res_valid  = (state_q == DONE);
    assign Cost       = table_full ? rdata : '0;

    always_ff @(posedge CLK) begin
        if (RST)                                idx_q <= '0;
        else if (we)                            idx_q <= idx_q + 1'b1;
        else if (state_q == DONE && restart)    idx_q <= '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            res_min_cost    <= '0;
            res_match_count <= '0;
        end else if (state_q == SERVE && Valid) begin
            res_min_cost    <= MinCost;
            res_match_count <= MatchCount;
        end
    end

    // A result arriving before the table is complete is a protocol error; held until reset.
    always_ff @(posedge CLK) begin
        if (RST)                          err <= 1'b0;
        else if (state_q == LOAD && Valid) err <= 1'b1;
    end

    jam_cost_table #(.DEPTH(DEPTH), .WIDTH(COST_W)) u_table (
        .CLK   (CLK),
        .we    (we),
        .waddr (idx_q),
        .wdata (load_data),
        .raddr (jam_idx(W, J)),
        .rdata (rdata)
    );

`ifdef JAM_QUERY_CNT_EN
    logic [AW-1:0] prev_wj;
    logic [15:0]   qcnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_wj <= '0;
            qcnt    <= '0;
        end else begin
            prev_wj <= jam_idx(W, J);
            if (state_d == LOAD && state_q != LOAD)
                qcnt <= '0;
            else if (state_q == SERVE && jam_idx(W, J) != prev_wj && qcnt != 16'hFFFF)
                qcnt <= qcnt + 16'd1;
        end
    end

    assign query_cnt = qcnt;
`else
    assign query_cnt = '0;
`endif
endmodule

// File: tb/tb_jam_cost_server.sv
// Randomized scoreboard bench for jam_cost_server: lookups and captured results checked by monitors.
module tb_jam_cost_server;
    logic        CLK = 1'b0;
    logic        RST, load_valid, load_ready, Valid, table_full, res_valid, err, restart;
    logic [6:0]  load_data, Cost;
    logic [2:0]  W, J;
    logic [9:0]  MinCost, res_min_cost;
    logic [3:0]  MatchCount, res_match_count;
    logic [15:0] query_cnt;

    jam_cost_server dut (
        .CLK(CLK), .RST(RST), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .W(W), .J(J), .Cost(Cost), .Valid(Valid),
        .MinCost(MinCost), .MatchCount(MatchCount), .table_full(table_full),
        .res_valid(res_valid), .res_min_cost(res_min_cost),
        .res_match_count(res_match_count), .err(err), .restart(restart),
        .query_cnt(query_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct { int mc; int cnt; } res_t;

    int   total = 0, bad = 0;
    int   cost_q[$];
    res_t res_q[$];
    logic q_vld = 1'b0;
    logic rv_prev = 1'b0;

    // Behavioural model of the table and the protocol.
    int  mdl_tbl[64];
    int  nd[64];
    bit  mdl_full = 0, mdl_done = 0, mdl_err = 0;
    int  mdl_mc = 0, mdl_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Cost monitor: every engine lookup strobe has one queued expectation.
    always @(negedge CLK) begin
        if (q_vld) begin
            if (cost_q.size() == 0) chk("cost_q_underflow", 1, 0);
            else chk("cost", int'(Cost), cost_q.pop_front());
        end
    end

    // Result monitor: each rising res_valid consumes one queued capture.
    always @(negedge CLK) begin
        res_t r;
        if (res_valid && !rv_prev) begin
            if (res_q.size() == 0) chk("res_q_underflow", 1, 0);
            else begin
                r = res_q.pop_front();
                chk("res_min_cost", int'(res_min_cost), r.mc);
                chk("res_match_count", int'(res_match_count), r.cnt);
            end
        end
        rv_prev = res_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic lookup(input int w, input int j);
        W = 3'(w); J = 3'(j); q_vld = 1'b1;
        cost_q.push_back(mdl_full ? mdl_tbl[w*8+j] : 0);
        tick();
        q_vld = 1'b0;
    endtask

    task automatic rand_lookups(input int n);
        for (int i = 0; i < n; i++) lookup($urandom_range(7), $urandom_range(7));
    endtask

    task automatic send_result(input int mc, input int cnt);
        Valid = 1'b1; MinCost = 10'(mc); MatchCount = 4'(cnt);
        if (!mdl_full) mdl_err = 1;
        else if (!mdl_done) begin
            res_q.push_back('{mc, cnt});
            mdl_mc = mc; mdl_cnt = cnt; mdl_done = 1;
        end
        tick();
        Valid = 1'b0;
    endtask

    task automatic do_restart(input bit with_valid);
        restart = 1'b1; Valid = with_valid; MinCost = 10'd5; MatchCount = 4'd9;
        if (mdl_done) begin mdl_full = 0; mdl_done = 0; end
        tick();
        restart = 1'b0; Valid = 1'b0;
    endtask

    // Streams nd[] into the table; stops after stop_at accepts, optionally pulses Valid at err_at.
    task automatic do_load(input bit gappy, input int stop_at, input int err_at, output int cycles);
        int k = 0;
        bit lv, pulsed = 0;
        cycles = 0;
        while (k < stop_at && cycles < 1000) begin
            lv = gappy ? (cycles % 2 == 0) : 1'b1;
            load_valid = lv; load_data = 7'(nd[k]);
            if (lv && k == err_at && !pulsed) begin
                Valid = 1'b1; pulsed = 1; mdl_err = 1;
            end
            @(negedge CLK);
            if (lv && k == 63) chk("full_before_last", int'(table_full), 0);
            tick();
            if (Valid) begin
                Valid = 1'b0;
                chk("err_set", int'(err), 1);
            end
            if (lv) begin mdl_tbl[k] = nd[k]; k++; end
            cycles++;
        end
        load_valid = 1'b0;
        if (k < stop_at) chk("load_timeout", k, stop_at);
        if (k == 64) mdl_full = 1;
    endtask

    initial begin
        int cyc;
        RST = 1'b1; load_valid = 0; load_data = 0; W = 0; J = 0;
        Valid = 0; MinCost = 0; MatchCount = 0; restart = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_load_ready", int'(load_ready), 1);
        chk("rst_table_full", int'(table_full), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_min_cost", int'(res_min_cost), 0);
        chk("rst_res_match_count", int'(res_match_count), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_query_cnt", int'(query_cnt), 0);
        tick();
        lookup(3, 5);

        // Contiguous load of i%100.
        for (int i = 0; i < 64; i++) nd[i] = i % 100;
        do_load(0, 64, -1, cyc);
        chk("full_after_last", int'(table_full), 1);
        chk("serve_load_ready", int'(load_ready), 0);
        chk("contig_cycles", cyc, 64);
        lookup(3, 5);
        lookup(7, 7);
        rand_lookups(10);

        send_result(256, 3);
        chk("res_valid_next", int'(res_valid), 1);
        send_result(5, 1);
        chk("done_hold_mc", int'(res_min_cost), 256);
        chk("done_hold_cnt", int'(res_match_count), 3);
        rand_lookups(3);

        do_restart(1'b1);
        chk("restart_load_ready", int'(load_ready), 1);
        chk("restart_res_valid", int'(res_valid), 0);
        chk("restart_table_full", int'(table_full), 0);
        chk("restart_keep_mc", int'(res_min_cost), 256);
        chk("restart_keep_cnt", int'(res_match_count), 3);
        chk("restart_query_cnt", int'(query_cnt), 0);
        lookup(2, 2);

        // Gappy load with an early result strobe at idx 20.
        for (int i = 0; i < 64; i++) nd[i] = $urandom_range(127);
        nd[10] = 10;
        do_load(1, 64, 20, cyc);
        chk("gappy_cycles", cyc, 127);
        chk("err_in_serve", int'(err), int'(mdl_err));
        chk("no_capture_in_load", int'(res_min_cost), 256);
        lookup(1, 2);
        rand_lookups(10);
        send_result($urandom_range(1023), $urandom_range(15));
        chk("err_in_done", int'(err), 1);
        do_restart(1'b0);

        // Reset in the middle of a load, then reload.
        for (int i = 0; i < 64; i++) nd[i] = $urandom_range(127);
        do_load(0, 40, -1, cyc);
        RST = 1'b1; load_valid = 1'b1; load_data = 7'h55;
        tick();
        RST = 1'b0; load_valid = 1'b0;
        mdl_err = 0;
        chk("midrst_load_ready", int'(load_ready), 1);
        chk("midrst_table_full", int'(table_full), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_res_mc", int'(res_min_cost), 0);
        for (int i = 0; i < 64; i++) nd[i] = $urandom_range(127);
        do_load(0, 64, -1, cyc);
        rand_lookups(16);
        send_result($urandom_range(1023), $urandom_range(15));
        chk("final_err", int'(err), int'(mdl_err));

        repeat (3) tick();
        chk("cost_q_empty", cost_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jam_cost_server.md
# jam_cost_server

Responder side of the job-assignment cost interface. Holds an 8×8 table of 7-bit worker/job costs, loaded once through a valid/ready stream. It answers the assignment engine's (W, J) lookups with a same-cycle Cost and captures the engine's final MinCost/MatchCount when Valid is asserted. It sits between the stimulus/host loader and the assignment engine, so the engine never touches the raw cost source.

## Interface
Parameters:
- N_WORKERS, 8, table dimension per side; fixed, both W and J are 3 bits.
- COST_W, 7, cost word width.

Ports:
- CLK  in  1  single clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- load_valid  in  1  load word present.
- load_data  in  7  cost word, row-major: index = W*8+J.
- load_ready  out  1  table accepting words.
- W  in  3  worker index from engine.
- J  in  3  job index from engine.
- Cost  out  7  table[W][J], combinational from W/J while serving.
- Valid  in  1  engine result strobe.
- MinCost  in  10  engine result.
- MatchCount  in  4  engine result.
- table_full  out  1  all 64 words loaded; engine may start.
- res_valid  out  1  result captured.
- res_min_cost  out  10  captured MinCost.
- res_match_count  out  4  captured MatchCount.
- err  out  1  sticky protocol error.
- restart  in  1  leave DONE and reload.

## Operation
- FSM states: LOAD, SERVE, DONE. Reset → LOAD.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid=1 writes table[idx] and increments idx (6-bit).
  - Accepting idx=63 → SERVE next cycle; idx wraps to 0.
- SERVE:
  - table_full=1, load_ready=0.
  - Cost = table[{W,J}] with no register.
  - load_valid is ignored; it is not an error.
- Valid=1 in SERVE:
  - Capture MinCost/MatchCount into res_* on that edge.
  - Next state DONE, res_valid=1.
- DONE:
  - res_* held, table_full stays 1, Cost still served.
  - Further Valid pulses are ignored.
  - restart=1 → LOAD. idx=0, table_full=0, res_valid=0. res_* keep their old values until the next capture.
- restart is ignored in LOAD and SERVE.
- err is set when Valid=1 in LOAD (result before table complete). It is sticky until RST.
- Outside SERVE/DONE, Cost=0.

## Timing
- Reset values:
  - load_ready=1 (state LOAD after the reset edge).
  - table_full=0, res_valid=0, res_min_cost=0, res_match_count=0, err=0, Cost=0.
  - idx=0.
  - Table contents are not cleared.
- Load throughput is one word per cycle. Minimum 64 cycles from the first accept to table_full.
- table_full rises on the edge after the 64th accept.
- Cost lookup latency is 0 cycles (combinational). The engine registers it on its next edge.
- res_valid rises 1 cycle after the Valid edge.
- Simultaneous events:
  - RST beats everything: load, restart, Valid.
  - Valid and restart in the same DONE cycle: restart wins, Valid is ignored.
- RST mid-load discards the partial load; idx=0.

## Configuration
- JAM_QUERY_CNT_EN defined:
  - query_cnt (out, 16) counts cycles in SERVE where {W,J} differs from the previous cycle's value.
  - Saturates at 16'hFFFF.
  - Cleared by RST and on entry to LOAD.
- JAM_QUERY_CNT_EN undefined:
  - query_cnt port is still present and tied to 0.
  - No counter logic.

## Structure
- Shared package jam_pkg holds:
  - JAM_N=8, COST_W=7, SUM_W=10, CNT_W=4.
  - The state enum {LOAD, SERVE, DONE}.
  - The row-major index function {W,J}.
- Sub-module jam_cost_table: 64×7 register file, one synchronous write port, one combinational read port. The FSM, index counter, capture registers and query counter live in jam_cost_server.

## Test plan
- Load stream with table[i]=i%100, no gaps:
  - table_full rises exactly 1 cycle after the 64th accept.
  - W=3, J=5 → Cost=29.
  - W=7, J=7 → Cost=63.
- Load with load_valid toggling every other cycle:
  - idx advances only on accepts.
  - table_full appears after 64 accepts (~128 cycles).
  - table[10]=10.
- In SERVE, pulse Valid with MinCost=10'd256, MatchCount=4'd3:
  - Next cycle res_valid=1, res_min_cost=256, res_match_count=3.
  - A second Valid with MinCost=5 leaves res_min_cost at 256.
- Valid=1 during LOAD at idx=20 → err=1 and stays 1 through SERVE. Only RST clears it.
- RST asserted at idx=40:
  - Next cycle load_ready=1, idx=0, table_full=0.
  - A full reload then works and Cost reflects the new data.
- In DONE, assert restart and Valid together → state LOAD, res_valid=0, res_* unchanged. With JAM_QUERY_CNT_EN, query_cnt=0.
